// File: rtl/div_ctrl_if.sv
// Pipeline and divider-core signals of the divide controller.
// div_ctrl uses the slave view. The pipeline/core side uses the master view.
interface div_ctrl_if;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] div_rs;
    logic [31:0] div_rt;
    logic        flush;
    logic        div_ready;
    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] dv_A;
    logic [31:0] dv_B;
    logic        dv_start;
    logic        dv_is_busbusy;
    logic [31:0] dv_Q;
    logic [31:0] dv_R;
    logic        dv_opreat_over;

    modport master (
        output div_valid, div_signed, div_rs, div_rt, flush,
               dv_Q, dv_R, dv_opreat_over,
        input  div_ready, stall_req, hilo_we, hi_out, lo_out,
               dv_A, dv_B, dv_start, dv_is_busbusy
    );

    modport slave (
        input  div_valid, div_signed, div_rs, div_rt, flush,
               dv_Q, dv_R, dv_opreat_over,
        output div_ready, stall_req, hilo_we, hi_out, lo_out,
               dv_A, dv_B, dv_start, dv_is_busbusy
    );
endinterface

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer. It sits in front of an unsigned 17-step divider core.
// It converts operands to magnitudes, sign-fixes the results and handles flush and rewind.
//
//   state  | meaning
//   IDLE   | ready for a request; core parked at count 0
//   LOAD   | first core step on the registered magnitudes
//   RUN    | core stepping until completion
//   FIX    | sign-correct core quotient/remainder into lo/hi
//   WB     | hilo_we strobe; core rewound to 0
//   DRAIN  | flushed op: keep stepping so the core is not left mid-count
//   REWIND | flushed op: rewind the finished core, no write
module div_ctrl (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_FIX, S_WB, S_DRAIN, S_REWIND
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] mag_a, mag_b;
    logic [31:0] hi_q, lo_q;
    logic        q_neg, r_neg;
    logic [31:0] abs_rs, abs_rt;
    logic        accept, fix_load;
    logic        start, busbusy, we, stall, ready;

    assign abs_rs = (bus.div_signed && bus.div_rs[31]) ? -bus.div_rs : bus.div_rs;
    assign abs_rt = (bus.div_signed && bus.div_rt[31]) ? -bus.div_rt : bus.div_rt;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busbusy   = 1'b0;
        we        = 1'b0;
        stall     = 1'b0;
        ready     = 1'b0;
        accept    = 1'b0;
        fix_load  = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                stall = bus.div_valid;
                if (bus.div_valid && !bus.flush) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                start     = 1'b1;
                stall     = 1'b1;
                state_nxt = bus.flush ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                start = 1'b1;
                stall = 1'b1;
                if (bus.flush)
                    state_nxt = S_DRAIN;
                else if (bus.dv_opreat_over)
                    state_nxt = S_FIX;
            end
            // Core sits at its final count here; start with busbusy low only holds it.
            S_FIX: begin
                start = 1'b1;
                stall = 1'b1;
                if (bus.flush) begin
                    state_nxt = S_REWIND;
                end else begin
                    fix_load  = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                we        = 1'b1;
                start     = 1'b1;
                busbusy   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                start = 1'b1;
                if (bus.dv_opreat_over)
                    state_nxt = S_REWIND;
            end
            S_REWIND: begin
                start     = 1'b1;
                busbusy   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            mag_a <= '0;
            mag_b <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mag_a <= abs_rs;
                mag_b <= abs_rt;
                q_neg <= bus.div_signed & (bus.div_rs[31] ^ bus.div_rt[31]);
                r_neg <= bus.div_signed & bus.div_rs[31];
            end
            if (fix_load) begin
                lo_q <= q_neg ? -bus.dv_Q : bus.dv_Q;
                hi_q <= r_neg ? -bus.dv_R : bus.dv_R;
            end
        end
    end

    assign bus.div_ready     = ready;
    assign bus.stall_req     = stall & ~rst;
    assign bus.hilo_we       = we;
    assign bus.dv_start      = start;
    assign bus.dv_is_busbusy = busbusy;
    assign bus.dv_A          = mag_a;
    assign bus.dv_B          = mag_b;
    assign bus.hi_out        = hi_q;
    assign bus.lo_out        = lo_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural divider core and an arithmetic reference model.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] last_hi, last_lo;

    always #5 clk = ~clk;

    div_ctrl_if bus();
    div_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Core model: one step per dv_start cycle up to 17. Completion is flagged on the final stepping cycle.
    logic [4:0] core_cnt;
    always @(posedge clk) begin
        if (rst) core_cnt <= 5'd0;
        else if (bus.dv_start) begin
            if (core_cnt == 5'd17) begin
                if (bus.dv_is_busbusy) core_cnt <= 5'd0;
            end else core_cnt <= core_cnt + 5'd1;
        end
    end
    assign bus.dv_opreat_over = (core_cnt == 5'd17) ||
        (core_cnt == 5'd16 && bus.dv_start && !bus.dv_is_busbusy);
    assign bus.dv_Q = (bus.dv_B == 32'd0) ? 32'hFFFF_FFFF : bus.dv_A / bus.dv_B;
    assign bus.dv_R = (bus.dv_B == 32'd0) ? bus.dv_A : bus.dv_A % bus.dv_B;

    function automatic void ref_div(input logic sgn, input logic [31:0] rs, rt,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint a, b, q, r;
        logic [63:0] qv, rv;
        logic [31:0] ma;
        if (rt == 32'd0) begin
            ma = (sgn && rs[31]) ? 32'd0 - rs : rs;
            lo = (sgn && rs[31]) ? 32'd1 : 32'hFFFF_FFFF;
            hi = (sgn && rs[31]) ? 32'd0 - ma : ma;
        end else if (sgn) begin
            a = $signed({{32{rs[31]}}, rs});
            b = $signed({{32{rt[31]}}, rt});
            q = a / b;
            r = a % b;
            qv = q;
            rv = r;
            lo = qv[31:0];
            hi = rv[31:0];
        end else begin
            lo = rs / rt;
            hi = rs % rt;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request at cycle 0 and observes 25 cycles. It applies a one-cycle flush at flush_cyc (-1 = none).
    task automatic do_op(input logic sgn, input logic [31:0] rs, rt, input int flush_cyc,
                         output int we_cyc, output int we_cnt, output int ready_cyc,
                         output int stall_err, output logic [31:0] hi, output logic [31:0] lo);
        logic exp_stall;
        we_cyc = -1; we_cnt = 0; ready_cyc = -1; stall_err = 0; hi = '0; lo = '0;
        bus.div_valid  = 1'b1;
        bus.div_signed = sgn;
        bus.div_rs     = rs;
        bus.div_rt     = rt;
        for (int k = 0; k < 25; k++) begin
            bus.flush = (k == flush_cyc);
            #1;
            exp_stall = (flush_cyc >= 0 && flush_cyc < 18) ? (k <= flush_cyc) : (k <= 18);
            if (bus.stall_req !== exp_stall) stall_err++;
            if (bus.hilo_we === 1'b1) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = k; hi = bus.hi_out; lo = bus.lo_out;
                end
            end
            if (k > 0 && bus.div_ready === 1'b1 && ready_cyc < 0) ready_cyc = k;
            @(posedge clk);
            #1;
            bus.div_valid = 1'b0;
            bus.flush     = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.flush = 1'b1;
        bus.div_rs = 32'd5; bus.div_rt = 32'd1;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.hi_out, bus.lo_out, bus.hilo_we, bus.stall_req, bus.dv_start,
             bus.dv_is_busbusy, bus.dv_A, bus.dv_B} !== '0)
            $display("FAIL reset_outputs: got hi=%h lo=%h we=%b stall=%b start=%b busy=%b A=%h B=%h, want all 0",
                     bus.hi_out, bus.lo_out, bus.hilo_we, bus.stall_req, bus.dv_start,
                     bus.dv_is_busbusy, bus.dv_A, bus.dv_B);
        else n_pass++;
        n_checks++;
        if (bus.div_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.div_ready);
        else n_pass++;
        rst = 1'b0; bus.div_valid = 1'b0; bus.flush = 1'b0;
        tick();
        last_hi = '0; last_lo = '0;
    endtask

    task automatic test_divu_basic();
        int wc, wn, rc, se;
        logic [31:0] hi, lo;
        do_op(1'b0, 32'd100, 32'd7, -1, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (wc !== 19 || wn !== 1) $display("FAIL divu_we_timing: got cyc=%0d cnt=%0d want cyc=19 cnt=1", wc, wn);
        else n_pass++;
        n_checks++;
        if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_100_7: got lo=%0d hi=%0d want lo=14 hi=2", lo, hi);
        else n_pass++;
        n_checks++;
        if (se !== 0) $display("FAIL divu_stall: got %0d bad cycles want 0", se);
        else n_pass++;
        n_checks++;
        if (rc !== 20) $display("FAIL divu_ready: got cyc=%0d want 20", rc);
        else n_pass++;
        last_hi = hi; last_lo = lo;
    endtask

    task automatic test_signed();
        logic        sg[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] a[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b[4]  = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] el[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] eh[4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        int wc, wn, rc, se;
        logic [31:0] hi, lo;
        for (int i = 0; i < 4; i++) begin
            do_op(sg[i], a[i], b[i], -1, wc, wn, rc, se, hi, lo);
            n_checks++;
            if (lo !== el[i] || hi !== eh[i] || wc !== 19)
                $display("FAIL signed_%0d: got lo=%h hi=%h cyc=%0d want lo=%h hi=%h cyc=19",
                         i, lo, hi, wc, el[i], eh[i]);
            else n_pass++;
            last_hi = hi; last_lo = lo;
        end
    endtask

    task automatic test_flush();
        int wc, wn, rc, se;
        logic [31:0] hi, lo;
        do_op(1'b0, 32'd50, 32'd5, 5, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (wn !== 0) $display("FAIL flush_run_no_we: got %0d strobes want 0", wn);
        else n_pass++;
        n_checks++;
        if (rc !== 19 || se !== 0) $display("FAIL flush_run_ready_stall: got ready=%0d stall_err=%0d want 19/0", rc, se);
        else n_pass++;
        n_checks++;
        if (bus.lo_out !== last_lo || bus.hi_out !== last_hi)
            $display("FAIL flush_run_hold: got lo=%h hi=%h want lo=%h hi=%h", bus.lo_out, bus.hi_out, last_lo, last_hi);
        else n_pass++;
        do_op(1'b0, 32'd6, 32'd3, -1, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (lo !== 32'd2 || hi !== 32'd0 || wc !== 19)
            $display("FAIL after_flush_6_3: got lo=%0d hi=%0d cyc=%0d want 2 0 19", lo, hi, wc);
        else n_pass++;
        last_hi = hi; last_lo = lo;
        do_op(1'b0, 32'd77, 32'd4, 18, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (wn !== 0 || rc !== 20 || bus.lo_out !== last_lo || bus.hi_out !== last_hi)
            $display("FAIL flush_fix: got we=%0d ready=%0d lo=%h want we=0 ready=20 lo=%h", wn, rc, bus.lo_out, last_lo);
        else n_pass++;
        do_op(1'b0, 32'd77, 32'd4, 19, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (wc !== 19 || wn !== 1 || lo !== 32'd19 || hi !== 32'd1)
            $display("FAIL flush_wb: got cyc=%0d cnt=%0d lo=%0d hi=%0d want 19 1 19 1", wc, wn, lo, hi);
        else n_pass++;
        last_hi = hi; last_lo = lo;
    endtask

    task automatic test_rst_mid();
        int wn = 0;
        int wc, rc, se;
        logic [31:0] hi, lo;
        bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.div_rs = 32'd1000; bus.div_rt = 32'd3;
        tick();
        bus.div_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.hi_out, bus.lo_out, bus.hilo_we, bus.stall_req, bus.dv_start,
             bus.dv_is_busbusy, bus.dv_A, bus.dv_B} !== '0)
            $display("FAIL rst_mid_outputs: got hi=%h lo=%h we=%b stall=%b start=%b busy=%b, want all 0",
                     bus.hi_out, bus.lo_out, bus.hilo_we, bus.stall_req, bus.dv_start, bus.dv_is_busbusy);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            if (bus.hilo_we === 1'b1) wn++;
            tick();
        end
        n_checks++;
        if (wn !== 0) $display("FAIL rst_mid_no_we: got %0d strobes want 0", wn);
        else n_pass++;
        do_op(1'b0, 32'd9, 32'd4, -1, wc, wn, rc, se, hi, lo);
        n_checks++;
        if (lo !== 32'd2 || hi !== 32'd1 || wc !== 19)
            $display("FAIL after_rst_9_4: got lo=%0d hi=%0d cyc=%0d want 2 1 19", lo, hi, wc);
        else n_pass++;
        last_hi = hi; last_lo = lo;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int we[$];
        logic [31:0] rh[$], rl[$];
        bus.div_valid = 1'b1; bus.div_signed = 1'b0; bus.div_rs = 32'd10; bus.div_rt = 32'd3;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.hilo_we === 1'b1) begin
                we.push_back(k); rh.push_back(bus.hi_out); rl.push_back(bus.lo_out);
            end
            if (bus.div_valid && bus.div_ready === 1'b1) acc.push_back(k);
            tick();
            if (acc.size() == 1) begin bus.div_rs = 32'd20; bus.div_rt = 32'd6; end
            if (acc.size() == 2) bus.div_valid = 1'b0;
        end
        bus.div_valid = 1'b0;
        n_checks++;
        if (acc.size() != 2 || we.size() != 2) begin
            $display("FAIL b2b_counts: got accepts=%0d strobes=%0d want 2 2", acc.size(), we.size());
        end else begin
            n_pass++;
            n_checks++;
            if (acc[0] != 0 || we[0] != acc[0] + 19 || we[1] != acc[1] + 19 || acc[1] != 20)
                $display("FAIL b2b_timing: got acc=%0d,%0d we=%0d,%0d want acc=0,20 we=19,39",
                         acc[0], acc[1], we[0], we[1]);
            else n_pass++;
            n_checks++;
            if (rl[0] !== 32'd3 || rh[0] !== 32'd1 || rl[1] !== 32'd3 || rh[1] !== 32'd2)
                $display("FAIL b2b_results: got (%0d,%0d) (%0d,%0d) want (3,1) (3,2)", rl[0], rh[0], rl[1], rh[1]);
            else n_pass++;
            last_hi = rh[1]; last_lo = rl[1];
        end
    endtask

    task automatic test_div_zero();
        logic        sg[2] = '{1'b0, 1'b1};
        logic [31:0] a[2]  = '{32'd123, 32'hFFFF_FFFB};
        int wc, wn, rc, se;
        logic [31:0] hi, lo, eh, el;
        for (int i = 0; i < 2; i++) begin
            do_op(sg[i], a[i], 32'd0, -1, wc, wn, rc, se, hi, lo);
            ref_div(sg[i], a[i], 32'd0, eh, el);
            n_checks++;
            if (wc !== 19 || lo !== el || hi !== eh)
                $display("FAIL div_zero_%0d: got cyc=%0d lo=%h hi=%h want 19 %h %h", i, wc, lo, hi, el, eh);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int wc, wn, rc, se;
        logic [31:0] hi, lo, eh, el, rs, rt;
        logic sgn;
        for (int i = 0; i < 20; i++) begin
            sgn = 1'($urandom_range(0, 1));
            rs  = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = 32'($urandom_range(1, 15));
                1:       rt = 32'd0 - 32'($urandom_range(1, 15));
                2:       begin rt = $urandom; rs = 32'($urandom_range(0, 1000)); end
                default: rt = $urandom;
            endcase
            do_op(sgn, rs, rt, -1, wc, wn, rc, se, hi, lo);
            ref_div(sgn, rs, rt, eh, el);
            n_checks++;
            if (lo !== el || hi !== eh || wc !== 19 || wn !== 1 || se !== 0)
                $display("FAIL random_%0d: s=%b %h/%h got lo=%h hi=%h cyc=%0d cnt=%0d serr=%0d want lo=%h hi=%h cyc=19",
                         i, sgn, rs, rt, lo, hi, wc, wn, se, el, eh);
            else n_pass++;
        end
    endtask

    initial begin
        bus.div_valid = 1'b0; bus.div_signed = 1'b0; bus.div_rs = '0; bus.div_rt = '0; bus.flush = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        test_div_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
